btn_conditioner: RTL and testbench

- Conditions the raw push-button inputs (step, inc, dec) before the debug/display unit uses them.
- Per channel: 2-FF synchroniser, debounce FSM, one-cycle press pulse, optional auto-repeat while held.
- Output pulses drive the single-step clock and the register-address inc/dec controls directly. Consumers need no edge detection or counting of their own.
- Runs entirely in the clk_500 domain.

---
 rtl/btn_conditioner.sv | 133 +++++++++++++
 tb/tb_btn_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per channel a 2-FF synchroniser, a debounce FSM, a one-cycle
// press strobe and optional auto-repeat while the button is held.
module btn_conditioner #(
  parameter int unsigned            NUM_BTN    = 3,
  parameter int unsigned            DEB_CYCLES = 10,
  parameter int unsigned            REP_DELAY  = 250,
  parameter int unsigned            REP_PERIOD = 50,
  parameter logic [NUM_BTN-1:0]     REP_MASK   = 3'b110
) (
  input  logic               clk_500,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               btn_busy
);

  localparam logic [7:0]  DebMax    = 8'(DEB_CYCLES);
  localparam logic [11:0] RepDelay  = 12'(REP_DELAY);
  localparam logic [11:0] RepPeriod = 12'(REP_PERIOD);

  typedef enum logic [1:0] {
    StIdle,
    StDebPress,
    StHeld,
    StDebRel
  } state_e;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] busy_vec;

  always_ff @(posedge clk_500) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_e      state_q;
    logic [7:0]  deb_q;
    logic [11:0] rep_q;
    logic        rep_first_q;
    logic        level_q;
    logic        pulse_q;
    logic        s;
    logic [11:0] rep_tgt;
    logic [11:0] rep_nxt;

    always_comb begin
      s       = sync2_q[i];
      rep_tgt = rep_first_q ? RepDelay : RepPeriod;
      rep_nxt = rep_q + 12'd1;
    end

    always_ff @(posedge clk_500) begin
      if (rst) begin
        state_q     <= StIdle;
        deb_q       <= '0;
        rep_q       <= '0;
        rep_first_q <= 1'b0;
        level_q     <= 1'b0;
        pulse_q     <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            level_q <= 1'b0;
            if (s) begin
              state_q <= StDebPress;
              deb_q   <= 8'd1;
            end
          end
          StDebPress: begin
            if (!s) begin
              state_q <= StIdle;
              deb_q   <= '0;
            end else if (deb_q < DebMax) begin
              deb_q <= deb_q + 8'd1;
            end else begin
              state_q     <= StHeld;
              level_q     <= 1'b1;
              pulse_q     <= 1'b1;
              rep_q       <= '0;
              rep_first_q <= 1'b1;
            end
          end
          StHeld: begin
            if (!s) begin
              state_q <= StDebRel;
              deb_q   <= 8'd1;
            end else if (REP_MASK[i]) begin
              // A strobe is never issued on the cycle right after another one, so even a
              // one-cycle repeat setting leaves a low cycle between pulses.
              if (rep_nxt >= rep_tgt && !pulse_q) begin
                pulse_q     <= 1'b1;
                rep_q       <= '0;
                rep_first_q <= 1'b0;
              end else begin
                rep_q <= rep_nxt;
              end
            end else begin
              rep_q <= '0;
            end
          end
          StDebRel: begin
            if (s) begin
              state_q <= StHeld;
            end else if (deb_q < DebMax) begin
              deb_q <= deb_q + 8'd1;
            end else begin
              state_q <= StIdle;
              level_q <= 1'b0;
              deb_q   <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
    assign busy_vec[i]  = (state_q != StIdle);
  end

  assign btn_busy = |busy_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected outputs per cycle are derived from the
// scenario timing and queued as stimulus is driven, then compared after each clock edge.
module tb_btn_conditioner;

  logic       clk_500;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_pulse;
  logic       btn_busy;

  btn_conditioner dut (
    .clk_500   (clk_500),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .btn_busy  (btn_busy)
  );

  initial clk_500 = 1'b0;
  always #5 clk_500 = ~clk_500;

  typedef struct packed {
    logic [2:0] level;
    logic [2:0] pulse;
    logic       busy;
  } exp_t;

  typedef struct {
    int   scn;
    int   t;
    exp_t e;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit in_rng(input int t, input int a, input int b);
    return (t >= a) && (t < b);
  endfunction

  function automatic logic [2:0] raw_at(input int scn, input int t);
    logic [2:0] r;
    r = '0;
    case (scn)
      0: r[0] = (t < 100);
      1: r[1] = (t < 5) || in_rng(t, 25, 28);
      2: r[1] = (t < 400);
      3: r[0] = (t < 400);
      4: r[2] = (t < 100) || in_rng(t, 104, 106);
      5: r[1] = (t < 60);
      6: r[2] = (t < 340);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic rst_at(input int scn, input int t);
    return (scn == 5 && t == 8) || (scn == 6 && t == 300);
  endfunction

  // Press edge sampled at t=0 gives the strobe at t=12; release sample at r gives level low at r+12.
  function automatic exp_t exp_at(input int scn, input int t);
    exp_t e;
    e = '0;
    case (scn)
      0: begin
        e.level[0] = in_rng(t, 12, 112);
        e.pulse[0] = (t == 12);
        e.busy     = in_rng(t, 2, 112);
      end
      1: e.busy = in_rng(t, 2, 7) || in_rng(t, 27, 30);
      2: begin
        e.level[1] = in_rng(t, 12, 412);
        e.pulse[1] = (t == 12) || (t == 262) || (t == 312) || (t == 362);
        e.busy     = in_rng(t, 2, 412);
      end
      3: begin
        e.level[0] = in_rng(t, 12, 412);
        e.pulse[0] = (t == 12);
        e.busy     = in_rng(t, 2, 412);
      end
      4: begin
        e.level[2] = in_rng(t, 12, 118);
        e.pulse[2] = (t == 12);
        e.busy     = in_rng(t, 2, 118);
      end
      5: begin
        if (t < 8) begin
          e.busy = (t >= 2);
        end else if (t > 8) begin
          e.level[1] = in_rng(t, 21, 72);
          e.pulse[1] = (t == 21);
          e.busy     = in_rng(t, 11, 72);
        end
      end
      6: begin
        if (t < 300) begin
          e.level[2] = in_rng(t, 12, 300);
          e.pulse[2] = (t == 12) || (t == 262);
          e.busy     = in_rng(t, 2, 300);
        end else if (t > 300) begin
          e.level[2] = in_rng(t, 313, 352);
          e.pulse[2] = (t == 313);
          e.busy     = in_rng(t, 303, 352);
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  always begin
    @(posedge clk_500);
    #1;
    if (sb.size() > 0) begin
      sb_item_t it;
      it = sb.pop_front();
      check_eq($sformatf("s%0d_t%0d_level", it.scn, it.t), 32'(btn_level), 32'(it.e.level));
      check_eq($sformatf("s%0d_t%0d_pulse", it.scn, it.t), 32'(btn_pulse), 32'(it.e.pulse));
      check_eq($sformatf("s%0d_t%0d_busy", it.scn, it.t), 32'(btn_busy), 32'(it.e.busy));
    end
  end

  int lens[7] = '{120, 40, 420, 420, 130, 80, 360};

  initial begin
    rst     = 1'b1;
    btn_raw = '0;
    for (int scn = 0; scn < 7; scn++) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk_500);
        #2;
        rst     = 1'b1;
        btn_raw = '0;
        sb.push_back('{scn: -1, t: k, e: exp_t'('0)});
      end
      for (int t = 0; t < lens[scn]; t++) begin
        @(posedge clk_500);
        #2;
        rst     = rst_at(scn, t);
        btn_raw = raw_at(scn, t);
        sb.push_back('{scn: scn, t: t, e: exp_at(scn, t)});
      end
    end
    @(posedge clk_500);
    #2;
    rst     = 1'b0;
    btn_raw = '0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk_500);
    #3;
    check_eq("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
